// File: rtl/alu_datapath_pipe.sv
// Register-file ALU datapath: single-cycle logic/arith/shift/compare ops plus an
// iterative shift-add multiplier that stalls the input for WIDTH cycles.
module alu_datapath_pipe #(
  parameter int WIDTH    = 16,
  parameter int REG_ADDR = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          OP,
  input  logic [REG_ADDR-1:0] ra,
  input  logic [REG_ADDR-1:0] rb,
  input  logic                im_mux,
  input  logic                pc_mux,
  input  logic [WIDTH-1:0]    immediate,
  input  logic [WIDTH-1:0]    pc,
  input  logic                regwrt,
  output logic                out_valid,
  output logic [WIDTH-1:0]    ALU_output,
  output logic [4:0]          flag,
  output logic                busy
);

  localparam int NREG = 1 << REG_ADDR;
  localparam int CW   = $clog2(WIDTH);
  localparam int M    = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [5:0]    W6   = 6'(WIDTH);

  localparam logic [7:0] OP_AND = 8'h01, OP_OR  = 8'h02, OP_XOR = 8'h03,
                         OP_ADD = 8'h05, OP_NOT = 8'h07, OP_SUB = 8'h09,
                         OP_CMP = 8'h0B, OP_MOV = 8'h0D, OP_MUL = 8'h0E,
                         OP_LSH = 8'h84, OP_ASH = 8'h86;

  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state;

  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [4:0]       flg;
  logic             wr_ok;
  logic [WIDTH:0]   sum, diff;
  logic [4:0]       sh;
  logic [5:0]       mag;
  logic [WIDTH-1:0] shl, shr_l, shr_a;

  logic [WIDTH-1:0]    mul_a, mul_b, mul_acc, mul_acc_nxt;
  logic [CW-1:0]       mul_cnt;
  logic [REG_ADDR-1:0] mul_rb;
  logic                mul_wr;

  assign in_ready = (state == IDLE);
  assign busy     = (state == MUL_RUN);

  assign op_a = im_mux ? immediate : rf[ra];
  assign op_b = pc_mux ? pc : rf[rb];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  // Shift amount is a signed 5-bit field; negative means shift right by |amt|.
  assign sh    = op_a[4:0];
  assign mag   = sh[4] ? (6'd32 - {1'b0, sh}) : {1'b0, sh};
  assign shl   = (mag >= W6) ? '0 : (op_b << mag);
  assign shr_l = (mag >= W6) ? '0 : (op_b >> mag);
  assign shr_a = (mag >= W6) ? {WIDTH{op_b[M]}} : WIDTH'($signed(op_b) >>> mag);

  assign mul_acc_nxt = mul_b[0] ? (mul_acc + mul_a) : mul_acc;

  always_comb begin
    res   = '0;
    flg   = flag;
    wr_ok = 1'b1;
    case (OP)
      OP_AND: res = op_a & op_b;
      OP_OR:  res = op_a | op_b;
      OP_XOR: res = op_a ^ op_b;
      OP_NOT: res = ~op_a;
      OP_MOV: res = op_a;
      OP_ADD: begin
        res    = sum[M:0];
        flg[0] = sum[WIDTH];
        flg[2] = (op_a[M] == op_b[M]) && (sum[M] != op_a[M]);
        flg[3] = (sum[M:0] == '0);
        flg[4] = sum[M];
      end
      OP_SUB: begin
        res    = diff[M:0];
        flg[0] = diff[WIDTH];
        flg[2] = (op_a[M] != op_b[M]) && (diff[M] != op_a[M]);
        flg[3] = (diff[M:0] == '0);
        flg[4] = diff[M];
      end
      OP_CMP: begin
        res    = op_b;
        wr_ok  = 1'b0;
        flg[1] = (op_a > op_b);
        flg[3] = (op_a == op_b);
        flg[4] = ($signed(op_a) > $signed(op_b));
      end
      OP_LSH: res = sh[4] ? shr_l : shl;
      OP_ASH: res = sh[4] ? shr_a : shl;
      default: wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ALU_output <= '0;
      flag       <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_rb     <= '0;
      mul_wr     <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (OP == OP_MUL) begin
            state   <= MUL_RUN;
            mul_a   <= op_a;
            mul_b   <= op_b;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_rb  <= rb;
            mul_wr  <= regwrt;
          end else begin
            ALU_output <= res;
            flag       <= flg;
            out_valid  <= 1'b1;
            if (regwrt && wr_ok) rf[rb] <= res;
          end
        end
        MUL_RUN: begin
          mul_acc <= mul_acc_nxt;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == LAST) begin
            state      <= IDLE;
            ALU_output <= mul_acc_nxt;
            out_valid  <= 1'b1;
            if (mul_wr) rf[mul_rb] <= mul_acc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
